// File: rtl/ps2_kbd_tx.sv
`timescale 1ns/1ps
// ps2_kbd_tx: device-side PS/2 keyboard transmitter fed from a byte FIFO.
// Define PS2_TX_HOST_INHIBIT_EN to add the host_inhibit abort/retransmit input.
module ps2_kbd_tx #(
    parameter int PS2DIV     = 4000,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_HALVES = 4
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
`ifdef PS2_TX_HOST_INHIBIT_EN
    input  logic                          host_inhibit,
`endif
    output logic                          in_ready,
    output logic                          ps2_kbd_clk_out,
    output logic                          ps2_kbd_data_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    // state | meaning
    // IDLE  | lines high, waiting for a queued (or retransmit) byte
    // SHIFT | clocking out the 11-bit frame, two half-periods per bit
    // GAP   | lines high for GAP_HALVES half-periods after the stop bit
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(PS2DIV);
    localparam int GW = $clog2(GAP_HALVES + 1) + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q;
    logic          full, push, pop, pending_q;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q;
    logic          tick, abort, load;
    logic [7:0]    load_byte;
    logic [10:0]   shreg_q, shreg_d;
    logic [3:0]    idx_q, idx_d;
    logic          phase_hi_q, phase_hi_d;
    logic          clk_q, clk_d, dat_q, dat_d;
    logic [GW-1:0] gap_q, gap_d;
`ifdef PS2_TX_HOST_INHIBIT_EN
    logic          retx_q, retx_d;
    logic [7:0]    byte_q, byte_d;
`endif

    // a push into a full FIFO still lands when the FSM pops on the same edge
    assign full       = (level_q == LW'(FIFO_DEPTH));
    assign in_ready   = !full;
    assign push       = in_valid && (!full || pop);
    assign overflow   = in_valid && full && !pop;
    assign fifo_level = level_q;

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            pending_q <= (level_q != '0);
        end
    end

    assign tick = (div_q == DW'(PS2DIV - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                              div_q <= '0;
        else if (state_q == IDLE || abort || tick) div_q <= '0;
        else                                       div_q <= div_q + DW'(1);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shreg_q    <= '1;
            idx_q      <= '0;
            phase_hi_q <= 1'b1;
            clk_q      <= 1'b1;
            dat_q      <= 1'b1;
            gap_q      <= '0;
`ifdef PS2_TX_HOST_INHIBIT_EN
            retx_q     <= 1'b0;
            byte_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            phase_hi_q <= phase_hi_d;
            clk_q      <= clk_d;
            dat_q      <= dat_d;
            gap_q      <= gap_d;
`ifdef PS2_TX_HOST_INHIBIT_EN
            retx_q     <= retx_d;
            byte_q     <= byte_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        phase_hi_d = phase_hi_q;
        clk_d      = clk_q;
        dat_d      = dat_q;
        gap_d      = gap_q;
        pop        = 1'b0;
        abort      = 1'b0;
        load       = 1'b0;
        load_byte  = mem[rd_ptr];
`ifdef PS2_TX_HOST_INHIBIT_EN
        retx_d     = retx_q;
        byte_d     = byte_q;
`endif
        case (state_q)
            IDLE: begin
                clk_d = 1'b1;
                dat_d = 1'b1;
`ifdef PS2_TX_HOST_INHIBIT_EN
                if (!host_inhibit) begin
                    if (retx_q) begin
                        load      = 1'b1;
                        load_byte = byte_q;
                        retx_d    = 1'b0;
                    end else if (pending_q && level_q != '0) begin
                        load = 1'b1;
                        pop  = 1'b1;
                    end
                end
`else
                if (pending_q && level_q != '0) begin
                    load = 1'b1;
                    pop  = 1'b1;
                end
`endif
                if (load) begin
                    shreg_d    = {1'b1, ~^load_byte, load_byte, 1'b0};
                    idx_d      = '0;
                    phase_hi_d = 1'b1;
                    dat_d      = 1'b0;
                    state_d    = SHIFT;
`ifdef PS2_TX_HOST_INHIBIT_EN
                    byte_d     = load_byte;
`endif
                end
            end
            SHIFT: begin
`ifdef PS2_TX_HOST_INHIBIT_EN
                if (host_inhibit && idx_q <= 4'd9) begin
                    abort   = 1'b1;
                    clk_d   = 1'b1;
                    dat_d   = 1'b1;
                    retx_d  = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end else
`endif
                if (tick) begin
                    if (phase_hi_q) begin
                        clk_d      = 1'b0;
                        phase_hi_d = 1'b0;
                    end else begin
                        clk_d = 1'b1;
                        if (idx_q == 4'd10) begin
                            dat_d   = 1'b1;
                            gap_d   = '0;
                            state_d = GAP;
                        end else begin
                            // next bit changes together with the clock rise
                            idx_d      = idx_q + 4'd1;
                            shreg_d    = {1'b0, shreg_q[10:1]};
                            dat_d      = shreg_q[1];
                            phase_hi_d = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                clk_d = 1'b1;
                dat_d = 1'b1;
                if (tick) begin
                    if (gap_q == GW'(GAP_HALVES - 1)) state_d = IDLE;
                    else                              gap_d   = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ps2_kbd_clk_out  = clk_q;
    assign ps2_kbd_data_out = dat_q;
`ifdef PS2_TX_HOST_INHIBIT_EN
    assign busy = (state_q != IDLE) || (level_q != '0) || retx_q;
`else
    assign busy = (state_q != IDLE) || (level_q != '0);
`endif

endmodule
